// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions: controller state encoding, default bank-select
// position, wait-counter width and index-width helpers.
package mem_map_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int unsigned DEF_SEL_LSB = 19;
    localparam int unsigned CNT_W       = 4;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned v;
        int unsigned r;
        v = 1;
        r = 0;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // A single bank still needs one index bit so that idx=1 can fault.
    function automatic int unsigned sel_width(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mem_bank_onehot_n.sv
// Combinational bank index to active-low one-hot select with enable.
// Indices at or beyond NUM_BANKS leave every select high.
module mem_bank_onehot_n #(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned SEL_W     = 1
) (
    input  logic [SEL_W-1:0]     idx,
    input  logic                 en,
    output logic [NUM_BANKS-1:0] sel_n
);

    always_comb begin
        sel_n = '1;
        for (int i = 0; i < int'(NUM_BANKS); i++) begin
            if (en && (idx == SEL_W'(i))) begin
                sel_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_bank_ctrl.sv
// Banked memory request controller: decodes a bank index from the request
// address, holds that bank's chip select for WAIT_CYC+1 cycles, then responds.
module mem_bank_ctrl
    import mem_map_pkg::*;
#(
    parameter  int unsigned ADDR_W    = 32,
    parameter  int unsigned NUM_BANKS = 2,
    parameter  int unsigned SEL_LSB   = DEF_SEL_LSB,
    parameter  int unsigned WAIT_CYC  = 1,
    localparam int unsigned SEL_W     = sel_width(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    output logic [NUM_BANKS-1:0] cs_n,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_fault,
    output logic [SEL_W-1:0]     rsp_bank,
    output logic                 busy
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_BANKS-1:0]   cs_n_q, cs_n_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_fault_q, rsp_fault_d;
    logic [SEL_W-1:0]       rsp_bank_q, rsp_bank_d;

    logic [SEL_W-1:0]       req_idx;
    logic                   idx_mapped;
    logic [NUM_BANKS-1:0]   dec_n;
    logic                   unused_addr_bits;

    assign req_idx    = req_addr[SEL_LSB +: SEL_W];
    assign idx_mapped = (32'(req_idx) < NUM_BANKS);

    // Address bits outside the index field are deliberately ignored.
    assign unused_addr_bits = ^req_addr;

    mem_bank_onehot_n #(
        .NUM_BANKS (NUM_BANKS),
        .SEL_W     (SEL_W)
    ) u_onehot (
        .idx   (req_idx),
        .en    (idx_mapped),
        .sel_n (dec_n)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        cs_n_d      = cs_n_q;
        rsp_valid_d = rsp_valid_q;
        rsp_fault_d = rsp_fault_q;
        rsp_bank_d  = rsp_bank_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rsp_bank_d = req_idx;
                    if (idx_mapped) begin
                        state_d     = ACCESS;
                        cnt_d       = CNT_W'(WAIT_CYC);
                        cs_n_d      = dec_n;
                        rsp_fault_d = 1'b0;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    cs_n_d      = '1;
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                cs_n_d      = '1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Async reset drops every chip select at once and discards any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cs_n_q      <= '1;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_bank_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cs_n_q      <= cs_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_bank_q  <= rsp_bank_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign cs_n      = cs_n_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_bank  = rsp_bank_q;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Self-checking bench for mem_bank_ctrl (3 banks, 2 wait cycles): directed
// scenarios plus random traffic compared each cycle against a transaction model.
module tb_mem_bank_ctrl;

    localparam int ADDR_W   = 32;
    localparam int NB       = 3;
    localparam int SEL_LSB  = 19;
    localparam int WAIT_CYC = 2;
    localparam int SEL_W    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [NB-1:0]     cs_n;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_fault;
    logic [SEL_W-1:0]  rsp_bank;
    logic              busy;

    always #5 clk = ~clk;

    mem_bank_ctrl #(
        .ADDR_W    (ADDR_W),
        .NUM_BANKS (NB),
        .SEL_LSB   (SEL_LSB),
        .WAIT_CYC  (WAIT_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .cs_n      (cs_n),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_fault (rsp_fault),
        .rsp_bank  (rsp_bank),
        .busy      (busy)
    );

    // Transaction-level model: cycles of chip select left, pending response.
    int m_cs_left;
    bit m_rsp;
    int m_bank;
    bit m_fault;
    int m_accepts;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    function automatic void model_reset();
        m_cs_left = 0;
        m_rsp     = 0;
        m_bank    = 0;
        m_fault   = 0;
    endfunction

    function automatic logic [31:0] addr_for(input int idx);
        logic [31:0] a;
        logic [31:0] i;
        a       = $urandom;
        i       = 32'(idx);
        a[20:19] = i[1:0];
        return a;
    endfunction

    // Applies one rising edge to the model using the inputs the DUT just sampled.
    function automatic void model_edge();
        int idx;
        if (m_rsp) begin
            if (rsp_ready) m_rsp = 0;
        end else if (m_cs_left > 0) begin
            m_cs_left--;
            if (m_cs_left == 0) begin
                m_rsp   = 1;
                m_fault = 0;
            end
        end else if (req_valid) begin
            idx = int'((req_addr >> SEL_LSB) & 32'h3);
            m_bank = idx;
            m_accepts++;
            if (idx < NB) begin
                m_cs_left = WAIT_CYC + 1;
            end else begin
                m_rsp   = 1;
                m_fault = 1;
            end
        end
    endfunction

    task automatic compare();
        int exp_cs;
        bit idle;
        exp_cs = (m_cs_left > 0) ? ((~(1 << m_bank)) & 7) : 7;
        idle   = (m_cs_left == 0) && !m_rsp;
        check("cs_n", 32'(cs_n), 32'(exp_cs));
        check("req_ready", 32'(req_ready), 32'(idle));
        check("busy", 32'(busy), 32'(!idle));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
        if (m_rsp) begin
            check("rsp_bank", 32'(rsp_bank), 32'(m_bank));
            check("rsp_fault", 32'(rsp_fault), 32'(m_fault));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    int seq[4] = '{0, 1, 0, 1};

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        model_reset();
        m_accepts = 0;

        #12;
        compare();
        check("rst_rsp_bank", 32'(rsp_bank), 32'd0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Mapped request to bank 1 through the legacy select bit.
        req_valid = 1'b1;
        req_addr  = 32'h0008_0000;
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (6) step();

        // Unmapped bank 3, consumer stalls for 5 cycles.
        req_valid = 1'b1;
        req_addr  = 32'h0018_0000;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        repeat (5) step();
        check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        check("stall_rsp_fault", 32'(rsp_fault), 32'd1);
        rsp_ready = 1'b1;
        step();
        check("release_ready", 32'(req_ready), 32'd1);
        step();

        // Back-to-back stream to banks 0,1,0,1 with the request held valid.
        m_accepts = 0;
        for (int c = 0; c < 40; c++) begin
            req_valid = (m_accepts < 4);
            req_addr  = addr_for(seq[(m_accepts < 4) ? m_accepts : 3]);
            step();
        end
        check("stream_accepts", 32'(m_accepts), 32'd4);
        req_valid = 1'b0;

        // Reset while a chip select is active.
        req_valid = 1'b1;
        req_addr  = addr_for(0);
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        check("pre_rst_cs_n", 32'(cs_n), 32'h6);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cs_n", 32'(cs_n), 32'h7);
        check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        compare();
        rst_n = 1'b1;
        repeat (8) step();

        // Random traffic, including address churn while busy.
        for (int c = 0; c < 600; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = addr_for(int'($urandom_range(0, 3)));
            rsp_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        check("random_accepts", 32'(m_accepts > 20), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bank_ctrl.md
Name: mem_bank_ctrl

Overview:
- Parametrised successor to the two-bank instruction-memory select decoder.
- Accepts one memory request at a time over a valid/ready handshake and decodes a bank index from a configurable address field.
- Drives one-hot active-low chip selects for a programmable number of wait states, then returns a response with a fault flag for unmapped banks.
- Sits between the fetch/load-store address path and the banked instruction/data memories.

Parameters:
- ADDR_W, 32, request address width.
- NUM_BANKS, 2, number of memory banks / chip selects (1..16; need not be a power of 2).
- SEL_LSB, 19, LSB of the bank-index field in req_addr.
- SEL_W, max(1, clog2(NUM_BANKS)), bank-index field width (derived localparam, not overridable).
- WAIT_CYC, 1, extra cycles cs_n is held after the first access cycle (0..15).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  ADDR_W  request address; sampled only on handshake.
- cs_n  out  NUM_BANKS  chip selects, active low, at most one low.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_fault  out  1  decoded bank index >= NUM_BANKS; valid with rsp_valid.
- rsp_bank  out  SEL_W  decoded bank index; valid with rsp_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, cs_n all 1, rsp_valid=0, rsp_fault=0, rsp_bank=0, counter=0.
  - req_ready=1 once reset is released.
  - Reset mid-access raises every cs_n immediately; no response is produced for the aborted request.
- All outputs are driven from registers; no combinational path from req_* or rsp_ready to any output.
- Bank index: idx = req_addr[SEL_LSB +: SEL_W], latched on handshake (req_valid & req_ready at a rising edge).
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On handshake with idx < NUM_BANKS: enter ACCESS, load counter=WAIT_CYC, drive cs_n[idx]=0.
  - On handshake with idx >= NUM_BANKS: enter RESP with rsp_fault=1; cs_n stays all 1.
- ACCESS:
  - req_ready=0; cs_n[idx] held low.
  - When counter==0: enter RESP, set all cs_n=1, rsp_valid=1, rsp_fault=0.
  - Otherwise decrement counter.
  - cs_n is low for exactly WAIT_CYC+1 cycles.
- RESP:
  - rsp_valid=1 with rsp_bank/rsp_fault held stable until rsp_ready.
  - On rsp_valid & rsp_ready: clear rsp_valid and return to IDLE.
  - There is no same-cycle acceptance of a new request; at least one IDLE cycle separates requests.
- Latency, handshake at edge T:
  - Mapped request: cs_n low during cycles T+1..T+1+WAIT_CYC; rsp_valid first high at T+2+WAIT_CYC.
  - Unmapped request: rsp_valid at T+1; cs_n never asserted.
- req_addr changes while not ready have no effect.
- Address bits outside the index field are ignored.
- NUM_BANKS=1: SEL_W=1; idx=1 faults.
- NUM_BANKS=2, SEL_LSB=19: cs_n[0] low iff addr[19]=0 and cs_n[1] low iff addr[19]=1, matching the legacy two-bank decode.

Decomposition:
- Shared mem_map_pkg (package/include) contains:
  - state encoding constants (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - default SEL_LSB;
  - wait-counter width (4);
  - a clog2 function for SEL_W.
- One natural sub-module: mem_bank_onehot_n, a combinational index -> active-low one-hot with enable, reused by the data-side decoder.

Test Plan:
- Reset, then NUM_BANKS=2, WAIT_CYC=1; req addr 0x0008_0000 -> cs_n=2'b01 for 2 cycles from T+1; rsp_valid at T+3 with rsp_bank=1, rsp_fault=0.
- NUM_BANKS=3, WAIT_CYC=0; addr bits[20:19]=2'b11 -> rsp_valid at T+1, rsp_fault=1, rsp_bank=3, cs_n stays 3'b111 throughout.
- rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_bank and rsp_fault stable, req_ready=0, cs_n all 1; release -> IDLE next cycle, req_ready=1.
- rst_n pulsed low during ACCESS with WAIT_CYC=3 -> cs_n all 1 in the same cycle without a clock edge; after release: req_ready=1, rsp_valid=0, and no late response appears.
- Back-to-back stream of 4 requests to banks 0,1,0,1 with rsp_ready=1 -> responses in order; never more than one cs_n low; one idle cycle between accesses.
- req_valid toggling and req_addr changing during ACCESS -> no effect on cs_n, rsp_bank or counter timing.
